// File: rtl/ay_reset_sequencer.sv
// rtl/ay_reset_sequencer.sv - merged chip reset and configuration latch sequencer for the ay38500 core
//
// Gathers power-on, keyboard, host, game-mode-change and dip-switch-change
// reset sources into one registered active-low chip reset. The reset is held
// for at least HOLD_CYCLES clocks per event. Game mode and configuration are
// latched only while the chip is held in reset.
//
// Optional feature macro: VSYNC_ALIGN_EN
//   defined   - reset release waits in ALIGN for a synchronised vsync rising
//               edge, or for SYNC_TIMEOUT clocks, whichever comes first.
//   undefined - release happens straight after the hold; vsync is unused.
//
// Ports:
//   clk           system clock (clkvga domain)
//   rst           asynchronous active-high reset, clears all state
//   key_reset     level reset request from keyboard (clk domain)
//   host_reset_n  active-low host reset (clk50 domain, synchronised here)
//   game_req      requested one-hot game mode
//   cfg_req       requested {batSize,ballSpeed,ballAngle,manServe}
//   vsync         vertical sync (asynchronous, synchronised here)
//   chip_reset_n  active-low reset to the ay38500
//   game_out      latched one-hot game mode
//   cfg_out       latched configuration bits
//   busy          high whenever the sequencer is not idle
//   done          one-cycle pulse on the cycle chip reset is released

module ay_reset_sequencer #(
    parameter int HOLD_CYCLES  = 128,
    parameter int SYNC_TIMEOUT = 1048576
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_reset,
    input  logic       host_reset_n,
    input  logic [6:0] game_req,
    input  logic [3:0] cfg_req,
    input  logic       vsync,
    output logic       chip_reset_n,
    output logic [6:0] game_out,
    output logic [3:0] cfg_out,
    output logic       busy,
    output logic       done
);

    localparam int MAXC = (HOLD_CYCLES > SYNC_TIMEOUT) ? HOLD_CYCLES : SYNC_TIMEOUT;
    localparam int CW   = (MAXC > 2) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_ASSERT   = 2'd0,
        ST_WAIT_REL = 2'd1,
        ST_IDLE     = 2'd3
`ifdef VSYNC_ALIGN_EN
        ,
        ST_ALIGN    = 2'd2
`endif
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          load;

    // Host reset crosses from clk50; idles high so a cold start is not
    // mistaken for a host request.
    logic [1:0] host_sync;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            host_sync <= 2'b11;
        end else begin
            host_sync <= {host_sync[0], host_reset_n};
        end
    end

`ifdef VSYNC_ALIGN_EN
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(SYNC_TIMEOUT - 1);

    // Two flops for metastability, a third to find the rising edge.
    logic [2:0] vs_sync;
    logic       vs_rise;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_sync <= 3'b000;
        end else begin
            vs_sync <= {vs_sync[1:0], vsync};
        end
    end
    assign vs_rise = vs_sync[1] & ~vs_sync[2];
`else
    logic unused_vsync;
    assign unused_vsync = vsync;
`endif

    logic game_valid;
    logic level_req;
    logic chg_req;
    logic req;

    assign game_valid = $onehot(game_req);
    assign level_req  = key_reset | ~host_sync[1];
    // Zero or multi-hot game requests never count as a change.
    assign chg_req    = (game_valid && (game_req != game_out)) || (cfg_req != cfg_out);
    assign req        = level_req | chg_req;

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        load      = 1'b0;
        case (state)
            ST_ASSERT: begin
                load = 1'b1;
                if (chg_req) begin
                    // A fresh change restarts the hold; it wins over terminal count.
                    count_nxt = '0;
                end else if (count == HOLD_LAST) begin
                    count_nxt = '0;
                    if (level_req) begin
                        state_nxt = ST_WAIT_REL;
`ifdef VSYNC_ALIGN_EN
                    end else begin
                        state_nxt = ST_ALIGN;
`else
                    end else begin
                        state_nxt = ST_IDLE;
`endif
                    end
                end else begin
                    count_nxt = count + CW'(1);
                end
            end
            ST_WAIT_REL: begin
                if (!level_req) begin
                    state_nxt = ST_ASSERT;
                    count_nxt = '0;
                    load      = 1'b1;
                end
            end
`ifdef VSYNC_ALIGN_EN
            ST_ALIGN: begin
                if (req) begin
                    state_nxt = ST_ASSERT;
                    count_nxt = '0;
                    load      = 1'b1;
                end else if (vs_rise || (count == TIMEOUT_LAST)) begin
                    state_nxt = ST_IDLE;
                    count_nxt = '0;
                end else begin
                    count_nxt = count + CW'(1);
                end
            end
`endif
            ST_IDLE: begin
                if (req) begin
                    // Latch on entry so the new mode appears with the reset edge.
                    state_nxt = ST_ASSERT;
                    count_nxt = '0;
                    load      = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_ASSERT;
                count_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_ASSERT;
            count        <= '0;
            game_out     <= 7'h02;
            cfg_out      <= 4'h0;
            chip_reset_n <= 1'b0;
            busy         <= 1'b1;
            done         <= 1'b0;
        end else begin
            state        <= state_nxt;
            count        <= count_nxt;
            if (load && game_valid) begin
                game_out <= game_req;
            end
            if (load) begin
                cfg_out <= cfg_req;
            end
            chip_reset_n <= (state_nxt == ST_IDLE);
            busy         <= (state_nxt != ST_IDLE);
            done         <= (state_nxt == ST_IDLE) && (state != ST_IDLE);
        end
    end

endmodule
